// File: rtl/axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axil_slave_regs
// Brief    : AXI4-Lite slave with CTRL, six SCRATCH words and a read-only
//            STATUS word. Optional macro AXIL_SLAVE_REGS_SLVERR_EN makes
//            out-of-range accesses answer SLVERR instead of OKAY.
// Revision : 1.0
// ============================================================================
module axil_slave_regs #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [3:0]            S_AXI_AWCACHE,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  output logic [1:0]            S_AXI_BRESP,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [3:0]            S_AXI_ARCACHE,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [31:0]           CTRL_OUT,
  input  logic [31:0]           STATUS_IN
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLAVE_REGS_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif
  localparam logic [2:0] STATUS_IDX = 3'd7;

  typedef enum logic [1:0] {W_IDLE, W_PART, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  arready_q, arready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  // Entry 7 is never written; STATUS reads come from STATUS_IN instead.
  logic [31:0]           regs_q [8];
  logic [31:0]           regs_d [8];

  logic                  bvalid_now;
  logic                  bvalid_next;
  logic                  rvalid_now;
  logic                  rvalid_next;
  logic                  aw_in_range;
  logic                  ar_in_range;
  logic [2:0]            aw_idx;
  logic [2:0]            ar_idx;
  logic                  unused_bits;

  assign bvalid_now  = (w_state_q == W_RESP);
  assign rvalid_now  = (r_state_q == R_DATA);
  assign aw_in_range = (aw_addr_q[ADDR_WIDTH-1:5] == '0);
  assign ar_in_range = (S_AXI_ARADDR[ADDR_WIDTH-1:5] == '0);
  assign aw_idx      = aw_addr_q[4:2];
  assign ar_idx      = S_AXI_ARADDR[4:2];
  assign unused_bits = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE,
                         S_AXI_ARPROT, aw_addr_q[1:0], S_AXI_ARADDR[1:0]};

  // Write path: two single-entry slots, commit once both hold data and no
  // B response is outstanding.
  always_comb begin
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bresp_d     = bresp_q;
    bvalid_next = bvalid_now;
    regs_d      = regs_q;

    if (bvalid_now && S_AXI_BREADY) begin
      bvalid_next = 1'b0;
    end

    if (w_state_q == W_COMMIT) begin
      aw_full_d   = 1'b0;
      w_full_d    = 1'b0;
      bvalid_next = 1'b1;
      bresp_d     = aw_in_range ? RESP_OKAY : RESP_OOR;
      if (aw_in_range && (aw_idx != STATUS_IDX)) begin
        for (int i = 0; i < 4; i++) begin
          if (w_strb_q[i]) begin
            regs_d[aw_idx][8*i +: 8] = w_data_q[8*i +: 8];
          end
        end
      end
    end

    if (S_AXI_AWVALID && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR;
    end
    if (S_AXI_WVALID && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (bvalid_next) begin
      w_state_d = W_RESP;
    end else if (aw_full_d && w_full_d) begin
      w_state_d = W_COMMIT;
    end else if (aw_full_d || w_full_d) begin
      w_state_d = W_PART;
    end else begin
      w_state_d = W_IDLE;
    end

    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
  end

  // Read path: register file is sampled before any same-edge commit lands.
  always_comb begin
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rvalid_next = rvalid_now;

    if (rvalid_now && S_AXI_RREADY) begin
      rvalid_next = 1'b0;
    end
    if (S_AXI_ARVALID && arready_q) begin
      rvalid_next = 1'b1;
      if (ar_in_range) begin
        rresp_d = RESP_OKAY;
        rdata_d = (ar_idx == STATUS_IDX) ? STATUS_IN : regs_q[ar_idx];
      end else begin
        rresp_d = RESP_OOR;
        rdata_d = 32'h0;
      end
    end

    r_state_d = rvalid_next ? R_DATA : R_IDLE;
    arready_d = ~rvalid_next;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 32'h0;
      end
      regs_q[0] <= CTRL_RESET;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_now;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_now;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign CTRL_OUT      = regs_q[0];

endmodule
`default_nettype wire
